instnorm_stats_034: RTL

INSTNORM_STATS_034 -- requirements
Module: instnorm_stats_034

---
 rtl/instnorm_stats_034_pkg.sv | 15 +
 rtl/instnorm_stats_034_if.sv | 21 ++
 rtl/instnorm_stats_034_acc.sv | 56 +++++
 rtl/instnorm_stats_034.sv | 120 ++++++++++++
 4 files changed

// File: rtl/instnorm_stats_034_pkg.sv
// Shared types and constants for the instance-normalisation statistics block.
// The block collects one instance of samples, then emits its mean and variance.
package instnorm_pkg;
  localparam int SAMPLE_W = 16;
  localparam int STAT_W   = 32;

  localparam logic SEL_MEAN = 1'b0;
  localparam logic SEL_VAR  = 1'b1;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    MEAN = 2'd1,
    VAR  = 2'd2
  } state_e;
endpackage

// File: rtl/instnorm_stats_034_if.sv
// Sample-in and statistic-out handshake bundle.
// The slave side is the statistics block; the master side is its environment.
interface instnorm_stats_034_if;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] input_data;
  logic        valid_out;
  logic        out_ready;
  logic [31:0] output_data;
  logic        stat_sel;

  modport slave (
    input  valid_in, input_data, out_ready,
    output ready_in, valid_out, output_data, stat_sel
  );

  modport master (
    output valid_in, input_data, out_ready,
    input  ready_in, valid_out, output_data, stat_sel
  );
endinterface

// File: rtl/instnorm_stats_034_acc.sv
// Running sum / sum-of-squares / sample counter for one instance.
// Exposes the next sum so the caller can derive the mean on the final sample's edge.
module instnorm_acc
  import instnorm_pkg::*;
#(
  parameter int LOG2_N = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 clr,
  input  logic signed [SAMPLE_W-1:0]           x,
  output logic signed [SAMPLE_W+LOG2_N-1:0]    sum_d,
  output logic        [2*SAMPLE_W+LOG2_N-1:0]  sumsq_q,
  output logic                                 last
);
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  localparam int SQ_W  = 2 * SAMPLE_W + LOG2_N;

  logic signed [SUM_W-1:0]      sum_q;
  logic        [SQ_W-1:0]       sumsq_d;
  logic        [LOG2_N-1:0]     cnt_q;
  logic        [LOG2_N-1:0]     cnt_d;
  logic signed [2*SAMPLE_W-1:0] sq;

  assign sq   = 32'(x) * 32'(x);
  assign last = en & (cnt_q == '1);

  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    cnt_d   = cnt_q;
    if (clr) begin
      sum_d   = '0;
      sumsq_d = '0;
      cnt_d   = '0;
    end else if (en) begin
      // Widths carry LOG2_N guard bits, so a full instance can never overflow.
      sum_d   = sum_q + SUM_W'(x);
      sumsq_d = sumsq_q + SQ_W'($unsigned(sq));
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/instnorm_stats_034.sv
// Instance statistics: accepts 2^LOG2_N signed samples, then emits a mean beat
// followed by a variance beat before accepting the next instance.
module instnorm_stats_034
  import instnorm_pkg::*;
#(
  parameter int LOG2_N = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  instnorm_stats_034_if.slave    bus
);
  localparam int SUM_W = SAMPLE_W + LOG2_N;
  localparam int SQ_W  = 2 * SAMPLE_W + LOG2_N;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                sel_q, sel_d;
  logic [STAT_W-1:0]   data_q, data_d;
  logic [STAT_W-1:0]   msq_q, msq_d;

  logic                       take;
  logic                       clr;
  logic                       last;
  logic signed [SUM_W-1:0]    sum_d;
  logic        [SQ_W-1:0]     sumsq_q;
  logic signed [SUM_W-1:0]    sum_sh;
  logic signed [SAMPLE_W-1:0] mean_next;
  logic signed [STAT_W-1:0]   msq_next;
  logic        [STAT_W-1:0]   sumsq_sh;
  logic        [STAT_W+1:0]   var_diff;
  logic        [STAT_W-1:0]   var_val;
  logic                       unused_bits;

  assign take = bus.valid_in & ready_q;

  instnorm_acc #(.LOG2_N(LOG2_N)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (take),
    .clr     (clr),
    .x       (bus.input_data[SAMPLE_W-1:0]),
    .sum_d   (sum_d),
    .sumsq_q (sumsq_q),
    .last    (last)
  );

  // Arithmetic shift floors toward -inf; the quotient always fits in a sample.
  assign sum_sh    = sum_d >>> LOG2_N;
  assign mean_next = sum_sh[SAMPLE_W-1:0];
  assign msq_next  = 32'(mean_next) * 32'(mean_next);

  assign sumsq_sh = sumsq_q[SQ_W-1:LOG2_N];
  assign var_diff = {2'b00, sumsq_sh} - {2'b00, msq_q};
  assign var_val  = var_diff[STAT_W+1] ? '0 : var_diff[STAT_W-1:0];

  assign unused_bits = ^{bus.input_data[31:SAMPLE_W], sum_sh[SUM_W-1:SAMPLE_W],
                         sumsq_q[LOG2_N-1:0], var_diff[STAT_W]};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    data_d  = data_q;
    msq_d   = msq_q;
    clr     = 1'b0;
    case (state_q)
      ACC: begin
        if (last) begin
          state_d = MEAN;
          valid_d = 1'b1;
          sel_d   = SEL_MEAN;
          data_d  = STAT_W'(mean_next);
          msq_d   = $unsigned(msq_next);
        end
      end
      MEAN: begin
        if (bus.out_ready) begin
          state_d = VAR;
          sel_d   = SEL_VAR;
          data_d  = var_val;
        end
      end
      VAR: begin
        if (bus.out_ready) begin
          state_d = ACC;
          valid_d = 1'b0;
          sel_d   = SEL_MEAN;
          data_d  = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = ACC;
    endcase
    ready_d = (state_d == ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= SEL_MEAN;
      data_q  <= '0;
      msq_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      msq_q   <= msq_d;
    end
  end

  assign bus.ready_in    = ready_q;
  assign bus.valid_out   = valid_q;
  assign bus.stat_sel    = sel_q;
  assign bus.output_data = data_q;
endmodule
